wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/nano_rv32i_pkg.sv | 22 ++
 rtl/wb_arbiter_if.sv | 61 ++++++
 rtl/wb_scoreboard.sv | 77 +++++++
 rtl/wb_arbiter.sv | 100 ++++++++++
 4 files changed

// File: rtl/nano_rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nano_rv32i_pkg
// Purpose  : Shared widths and the write-back grant encoding for the nano
//            RV32I write-back path (arbiter, scoreboard, bus interface).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package nano_rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;

  // Records which channel won the most recent ALU/LD conflict.
  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LD  = 1'b1
  } grant_e;

endpackage : nano_rv32i_pkg
`default_nettype wire

// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_if
// Purpose  : Bundles every signal of the write-back arbiter except clock and
//            reset: the ALU and load-return handshakes, the load-issue and
//            decode-query scoreboard signals, and the regfile write port.
// Modports : slave  - seen from the arbiter (consumes *_i, drives *_o)
//            master - seen from the surrounding pipeline / bench
// Revision : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if #(
  parameter int XLEN  = nano_rv32i_pkg::XLEN,
  parameter int NREGS = nano_rv32i_pkg::NREGS
);
  import nano_rv32i_pkg::*;

  // ALU result channel
  logic                  alu_valid_i;
  logic                  alu_ready_o;
  logic [REG_ADDR_W-1:0] alu_rd_i;
  logic [XLEN-1:0]       alu_data_i;

  // Load-return channel
  logic                  ld_valid_i;
  logic                  ld_ready_o;
  logic [REG_ADDR_W-1:0] ld_rd_i;
  logic [XLEN-1:0]       ld_data_i;

  // Load issue and decode hazard query
  logic                  ld_issue_i;
  logic [REG_ADDR_W-1:0] ld_issue_rd_i;
  logic                  ld_issue_ready_o;
  logic [REG_ADDR_W-1:0] rs1_i;
  logic [REG_ADDR_W-1:0] rs2_i;
  logic                  stall_o;

  // Regfile write port and status
  logic                  reg_write_o;
  logic [REG_ADDR_W-1:0] rd_o;
  logic [XLEN-1:0]       write_data_o;
  logic [NREGS-1:0]      busy_o;
  logic [31:0]           wb_cnt_o;

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  ld_valid_i, ld_rd_i, ld_data_i,
    input  ld_issue_i, ld_issue_rd_i, rs1_i, rs2_i,
    output alu_ready_o, ld_ready_o, ld_issue_ready_o, stall_o,
    output reg_write_o, rd_o, write_data_o, busy_o, wb_cnt_o
  );

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    output ld_valid_i, ld_rd_i, ld_data_i,
    output ld_issue_i, ld_issue_rd_i, rs1_i, rs2_i,
    input  alu_ready_o, ld_ready_o, ld_issue_ready_o, stall_o,
    input  reg_write_o, rd_o, write_data_o, busy_o, wb_cnt_o
  );

endinterface : wb_arbiter_if
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : wb_scoreboard
// Purpose  : Tracks registers with an outstanding load. Issue sets a bit,
//            an accepted load return clears it, and decode is stalled when a
//            source register is still pending.
// Ports    : clk_i, rst_n_i          clock, synchronous active-low reset
//            ld_issue_i/_rd_i        load issued to memory (set request)
//            ld_clr_i/_rd_i          load return accepted (clear request)
//            rs1_i, rs2_i            decode source indices
//            ld_issue_ready_o        destination not already pending
//            stall_o                 a source is pending
//            busy_o                  registered busy vector
// Revision : 1.0 - initial release
// ============================================================================
module wb_scoreboard #(
  parameter int NREGS = nano_rv32i_pkg::NREGS
) (
  input  wire logic                                  clk_i,
  input  wire logic                                  rst_n_i,
  input  wire logic                                  ld_issue_i,
  input  wire logic [nano_rv32i_pkg::REG_ADDR_W-1:0] ld_issue_rd_i,
  input  wire logic                                  ld_clr_i,
  input  wire logic [nano_rv32i_pkg::REG_ADDR_W-1:0] ld_clr_rd_i,
  input  wire logic [nano_rv32i_pkg::REG_ADDR_W-1:0] rs1_i,
  input  wire logic [nano_rv32i_pkg::REG_ADDR_W-1:0] rs2_i,
  output logic                                       ld_issue_ready_o,
  output logic                                       stall_o,
  output logic [NREGS-1:0]                           busy_o
);
  import nano_rv32i_pkg::*;

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;

  // Looks up a busy bit; index 0 (x0) and out-of-range indices read as 0.
  function automatic logic f_busy(input logic [NREGS-1:0]      vec,
                                  input logic [REG_ADDR_W-1:0] idx);
    logic res;
    res = 1'b0;
    for (int k = 1; k < NREGS; k++) begin
      if (idx == REG_ADDR_W'(k)) res = vec[k];
    end
    return res;
  endfunction

  // Bit 0 has no set/clear decode, so x0 can never become busy. The set
  // is not gated by ld_issue_ready_o: on a bit that is already busy the
  // set is a no-op, except when the pending load returns in the same cycle,
  // where the new issue must win.
  for (genvar g = 0; g < NREGS; g++) begin : g_bit
    if (g == 0) begin : g_x0
      assign w_set[g] = 1'b0;
      assign w_clr[g] = 1'b0;
    end else begin : g_reg
      assign w_set[g] = ld_issue_i && (ld_issue_rd_i == REG_ADDR_W'(g));
      assign w_clr[g] = ld_clr_i   && (ld_clr_rd_i   == REG_ADDR_W'(g));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  // Both outputs look at the registered vector only: a load returning this
  // cycle still stalls decode until the clear has been registered.
  assign ld_issue_ready_o = ~f_busy(r_busy, ld_issue_rd_i);
  assign stall_o          = f_busy(r_busy, rs1_i) | f_busy(r_busy, rs2_i);
  assign busy_o           = r_busy;

endmodule : wb_scoreboard
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Merges ALU results and load returns onto the single regfile
//            write port with round-robin arbitration on conflicts, a one-cycle
//            registered write stage, a write counter, and a load scoreboard.
// Ports    : clk_i    clock
//            rst_n_i  synchronous active-low reset
//            bus      wb_arbiter_if.slave (handshakes, scoreboard, write port)
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int XLEN  = nano_rv32i_pkg::XLEN,
  parameter int NREGS = nano_rv32i_pkg::NREGS
) (
  input wire logic   clk_i,
  input wire logic   rst_n_i,
  wb_arbiter_if.slave bus
);
  import nano_rv32i_pkg::*;

  grant_e                r_last_grant;
  logic                  r_reg_write;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_write_data;
  logic [31:0]           r_wb_cnt;

  logic                  w_conflict;
  logic                  w_alu_ready;
  logic                  w_ld_ready;
  logic                  w_alu_acc;
  logic                  w_ld_acc;
  logic                  w_acc;
  logic [REG_ADDR_W-1:0] w_sel_rd;
  logic [XLEN-1:0]       w_sel_data;
  logic                  w_sel_wr;

  // On a conflict the channel that lost the previous conflict wins. Ready
  // depends only on the valids and r_last_grant, never on anything
  // downstream, so it stays meaningful even while reset is asserted.
  assign w_conflict  = bus.alu_valid_i & bus.ld_valid_i;
  assign w_alu_ready = bus.alu_valid_i & ~(bus.ld_valid_i  & (r_last_grant == GNT_ALU));
  assign w_ld_ready  = bus.ld_valid_i  & ~(bus.alu_valid_i & (r_last_grant == GNT_LD));

  assign w_alu_acc  = bus.alu_valid_i & w_alu_ready;
  assign w_ld_acc   = bus.ld_valid_i  & w_ld_ready;
  assign w_acc      = w_alu_acc | w_ld_acc;
  assign w_sel_rd   = w_ld_acc ? bus.ld_rd_i   : bus.alu_rd_i;
  assign w_sel_data = w_ld_acc ? bus.ld_data_i : bus.alu_data_i;
  // Writes to x0 are consumed but never reach the regfile or the counter.
  assign w_sel_wr   = w_acc && (w_sel_rd != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_last_grant <= GNT_ALU;
      r_reg_write  <= 1'b0;
      r_rd         <= '0;
      r_write_data <= '0;
      r_wb_cnt     <= '0;
    end else begin
      if (w_conflict) begin
        r_last_grant <= w_ld_acc ? GNT_LD : GNT_ALU;
      end
      r_reg_write <= w_sel_wr;
      if (w_acc) begin
        r_rd         <= w_sel_rd;
        r_write_data <= w_sel_data;
      end
      // Counter advances in step with reg_write_o, wrapping naturally.
      if (w_sel_wr) begin
        r_wb_cnt <= r_wb_cnt + 32'd1;
      end
    end
  end

  assign bus.alu_ready_o  = w_alu_ready;
  assign bus.ld_ready_o   = w_ld_ready;
  assign bus.reg_write_o  = r_reg_write;
  assign bus.rd_o         = r_rd;
  assign bus.write_data_o = r_write_data;
  assign bus.wb_cnt_o     = r_wb_cnt;

  wb_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .ld_issue_i       (bus.ld_issue_i),
    .ld_issue_rd_i    (bus.ld_issue_rd_i),
    .ld_clr_i         (w_ld_acc),
    .ld_clr_rd_i      (bus.ld_rd_i),
    .rs1_i            (bus.rs1_i),
    .rs2_i            (bus.rs2_i),
    .ld_issue_ready_o (bus.ld_issue_ready_o),
    .stall_o          (bus.stall_o),
    .busy_o           (bus.busy_o)
  );

endmodule : wb_arbiter
`default_nettype wire
